// File: rtl/adc_align_pkg.sv
// Shared constants and state encoding for the ADC lane alignment sequencer.
package adc_align_pkg;

  localparam int unsigned TimerWidth     = 16;
  localparam int unsigned DefNumLanes    = 8;
  localparam int unsigned DefLaneTimeout = 20000;
  localparam int unsigned DefMaxRetry    = 3;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StCfgTest  = 4'd1,
    StWaitFco  = 4'd2,
    StLaneGo   = 4'd3,
    StLaneWait = 4'd4,
    StLaneNext = 4'd5,
    StCfgNorm  = 4'd6,
    StFinish   = 4'd7,
    StDone     = 4'd8,
    StError    = 4'd9
  } seq_state_e;

  function automatic logic is_busy(seq_state_e s);
    return !(s inside {StIdle, StDone, StError});
  endfunction

endpackage

// File: rtl/adc_align_timer.sv
// Saturating cycle timer shared by the FCO wait and per-lane attempt windows.
module adc_align_timer
  import adc_align_pkg::*;
#(
  parameter int unsigned Limit = DefLaneTimeout
) (
  input  logic clk_ref,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  logic [TimerWidth-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + TimerWidth'(1);
    end
  end

  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the last cycle of a Limit-cycle window counted from load.
  assign expired = (count_q >= TimerWidth'(Limit - 1));

endmodule

// File: rtl/adc_align_seq.sv
// Serial ADC lane training sequencer: test-pattern config, FCO wait, per-lane
// delay training with retries, then restore normal mode and report.
module adc_align_seq
  import adc_align_pkg::*;
#(
  parameter int unsigned NUM_LANES    = DefNumLanes,
  parameter int unsigned LANE_TIMEOUT = DefLaneTimeout,
  parameter int unsigned MAX_RETRY    = DefMaxRetry
) (
  input  logic                         clk_ref,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         fco_aligned,
  output logic                         cfg_req,
  output logic                         cfg_test_mode,
  input  logic                         cfg_ack,
  output logic [NUM_LANES-1:0]         lane_start,
  input  logic [NUM_LANES-1:0]         lane_aligned,
  output logic [$clog2(NUM_LANES)-1:0] lane_sel,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [NUM_LANES-1:0]         lane_ok,
  output logic [3:0]                   seq_state
);

  localparam int unsigned SelW   = $clog2(NUM_LANES);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
  localparam logic [SelW-1:0]   LastLane  = SelW'(NUM_LANES - 1);
  localparam logic [RetryW-1:0] LastRetry = RetryW'(MAX_RETRY - 1);

  seq_state_e           state_q, state_d;
  logic [SelW-1:0]      sel_q, sel_d;
  logic [RetryW-1:0]    retry_q, retry_d;
  logic [NUM_LANES-1:0] lane_ok_q, lane_ok_d;
  logic                 fco_fail_q, fco_fail_d;
  logic                 cfg_req_q, cfg_req_d;
  logic                 cfg_mode_q, cfg_mode_d;
  logic [NUM_LANES-1:0] lane_start_q, lane_start_d;
  logic                 busy_q, done_q, error_q;
  logic                 timer_load, timer_en, timer_expired;

  // Any state change restarts the window, so each timed state starts at zero.
  assign timer_load = (state_d != state_q);
  assign timer_en   = (state_q == StWaitFco) || (state_q == StLaneWait);

  adc_align_timer #(
    .Limit(LANE_TIMEOUT)
  ) u_timer (
    .clk_ref(clk_ref),
    .reset  (reset),
    .load   (timer_load),
    .enable (timer_en),
    .expired(timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    retry_d    = retry_q;
    lane_ok_d  = lane_ok_q;
    fco_fail_d = fco_fail_q;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d    = StCfgTest;
          sel_d      = '0;
          retry_d    = '0;
          lane_ok_d  = '0;
          fco_fail_d = 1'b0;
        end
      end
      StCfgTest: if (cfg_ack) state_d = StWaitFco;
      StWaitFco: begin
        if (fco_aligned) begin
          state_d = StLaneGo;
        end else if (timer_expired) begin
          fco_fail_d = 1'b1;
          state_d    = StCfgNorm;
        end
      end
      StLaneGo: state_d = StLaneWait;
      StLaneWait: begin
        // Alignment seen on the expiry cycle still counts as a pass.
        if (lane_aligned[sel_q]) begin
          lane_ok_d[sel_q] = 1'b1;
          state_d          = StLaneNext;
        end else if (timer_expired) begin
          if (retry_q < LastRetry) begin
            retry_d = retry_q + RetryW'(1);
            state_d = StLaneGo;
          end else begin
            state_d = StLaneNext;
          end
        end
      end
      StLaneNext: begin
        retry_d = '0;
        if (sel_q == LastLane) begin
          state_d = StCfgNorm;
        end else begin
          sel_d   = sel_q + SelW'(1);
          state_d = StLaneGo;
        end
      end
      StCfgNorm: if (cfg_ack) state_d = StFinish;
      StFinish:  state_d = ((&lane_ok_q) && !fco_fail_q) ? StDone : StError;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with seq_state.
  always_comb begin
    lane_start_d = (state_d == StLaneGo) ? (NUM_LANES'(1) << sel_d) : '0;
    cfg_req_d    = (state_d == StCfgTest) || (state_d == StCfgNorm);
    cfg_mode_d   = cfg_mode_q;
    if (state_d == StCfgTest) begin
      cfg_mode_d = 1'b1;
    end else if (state_d == StCfgNorm) begin
      cfg_mode_d = 1'b0;
    end
  end

  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      sel_q        <= '0;
      retry_q      <= '0;
      lane_ok_q    <= '0;
      fco_fail_q   <= 1'b0;
      cfg_req_q    <= 1'b0;
      cfg_mode_q   <= 1'b0;
      lane_start_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      retry_q      <= retry_d;
      lane_ok_q    <= lane_ok_d;
      fco_fail_q   <= fco_fail_d;
      cfg_req_q    <= cfg_req_d;
      cfg_mode_q   <= cfg_mode_d;
      lane_start_q <= lane_start_d;
      busy_q       <= is_busy(state_d);
      done_q       <= (state_d == StDone);
      error_q      <= (state_d == StError);
    end
  end

  assign cfg_req       = cfg_req_q;
  assign cfg_test_mode = cfg_mode_q;
  assign lane_start    = lane_start_q;
  assign lane_sel      = sel_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign lane_ok       = lane_ok_q;
  assign seq_state     = state_q;

endmodule

// File: tb/tb_adc_align_seq.sv
// Bench for adc_align_seq: behavioural config port, FCO and lane engines plus a
// timing-level model of the expected lane_start trace and final result.
module tb_adc_align_seq;

  localparam int unsigned NL = 4;
  localparam int unsigned TO = 100;
  localparam int unsigned MR = 3;

  logic          clk_ref = 1'b0;
  logic          reset = 1'b1;
  logic          start_drv = 1'b0, noise_start = 1'b0;
  logic          ack_rsp = 1'b0, noise_ack = 1'b0;
  logic          fco_r = 1'b0;
  logic [NL-1:0] lane_al = '0;
  logic          cfg_req, cfg_test_mode, busy, done, error;
  logic [NL-1:0] lane_start, lane_ok;
  logic [1:0]    lane_sel;
  logic [3:0]    seq_state;

  int    n_cmp = 0, n_err = 0, cyc = 0;
  int    ack_dly = 3, fco_dly = 10;
  int    lane_dly[NL][MR];
  bit    env_clr = 1'b0, noise_en = 1'b0;
  int    ack_cnt = 0, fco_cnt = -1, last_pulse = -1, onehot_bad = 0;
  int    lane_cnt[NL], att[NL];
  string pulse_log = "", wr_log = "", exp_pulses = "";
  bit    exp_done, exp_error;
  logic [NL-1:0] exp_ok;

  adc_align_seq #(
    .NUM_LANES   (NL),
    .LANE_TIMEOUT(TO),
    .MAX_RETRY   (MR)
  ) dut (
    .clk_ref      (clk_ref),
    .reset        (reset),
    .start        (start_drv | noise_start),
    .fco_aligned  (fco_r),
    .cfg_req      (cfg_req),
    .cfg_test_mode(cfg_test_mode),
    .cfg_ack      (ack_rsp | noise_ack),
    .lane_start   (lane_start),
    .lane_aligned (lane_al),
    .lane_sel     (lane_sel),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .lane_ok      (lane_ok),
    .seq_state    (seq_state)
  );

  always #5 clk_ref = ~clk_ref;
  always @(posedge clk_ref) cyc <= cyc + 1;

  // Environment: config port, FCO source and per-lane delay engines.
  always @(negedge clk_ref) begin
    if (env_clr) begin
      lane_al = '0; ack_rsp = 0; noise_ack = 0; noise_start = 0; fco_r = 0;
      ack_cnt = 0; fco_cnt = -1; last_pulse = -1; pulse_log = ""; wr_log = "";
      for (int i = 0; i < NL; i++) begin lane_cnt[i] = 0; att[i] = 0; end
    end else begin
      noise_start = noise_en && busy && (cyc % 37 == 5);
      noise_ack   = noise_en && (last_pulse >= 0) && (cyc == last_pulse + 10);
      if (fco_cnt >= 0 && fco_dly != 0 && !fco_r) begin
        fco_cnt++;
        if (fco_cnt == fco_dly) fco_r = 1'b1;
      end
      if (ack_rsp) begin
        ack_rsp = 1'b0; ack_cnt = 0;
      end else if (cfg_req) begin
        ack_cnt++;
        if (ack_cnt >= ack_dly) begin
          ack_rsp = 1'b1;
          wr_log  = $sformatf("%s%0b", wr_log, cfg_test_mode);
          if (cfg_test_mode) fco_cnt = 0;
        end
      end
      if ($countones(lane_start) > 1) onehot_bad++;
      for (int i = 0; i < NL; i++) begin
        if (lane_start[i]) begin
          pulse_log = $sformatf("%sL%0d+%0d ", pulse_log, i,
                                (last_pulse < 0) ? 0 : cyc - last_pulse);
          last_pulse  = cyc;
          lane_al[i]  = 1'b0;
          lane_cnt[i] = (att[i] < MR) ? lane_dly[i][att[i]] : 0;
          att[i]++;
        end else if (lane_cnt[i] > 0) begin
          lane_cnt[i]--;
          if (lane_cnt[i] == 0) lane_al[i] = 1'b1;
        end
      end
    end
  end

  // Expected trace: a lane passes on an attempt whose align delay d is within
  // 1..TO; next pulse follows d+2 after a pass, TO+1 after a retry, TO+2 after
  // giving up on a lane.
  task automatic model_compute();
    int gap;
    exp_pulses = ""; exp_ok = '0; gap = 0;
    if (fco_dly != 0) begin
      for (int i = 0; i < NL; i++) begin
        for (int a = 0; a < MR; a++) begin
          exp_pulses = $sformatf("%sL%0d+%0d ", exp_pulses, i, gap);
          if (lane_dly[i][a] != 0 && lane_dly[i][a] <= int'(TO)) begin
            exp_ok[i] = 1'b1;
            gap = lane_dly[i][a] + 2;
            break;
          end
          gap = (a < int'(MR) - 1) ? int'(TO) + 1 : int'(TO) + 2;
        end
      end
    end
    exp_done  = (exp_ok == '1) && (fco_dly != 0);
    exp_error = !exp_done;
  endtask

  task automatic set_all(input int d);
    for (int i = 0; i < NL; i++) for (int a = 0; a < MR; a++) lane_dly[i][a] = d;
  endtask

  task automatic kick();
    env_clr = 1'b1; @(negedge clk_ref); #1 env_clr = 1'b0;
    @(negedge clk_ref); start_drv = 1'b1;
    @(negedge clk_ref); start_drv = 1'b0;
  endtask

  task automatic run_training(output bit ok);
    kick();
    ok = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk_ref); #1;
      if (done || error) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_ref);
    #1;
    n_cmp++; if (cfg_req !== 1'b0) begin n_err++; $display("FAIL reset cfg_req: got %b want 0", cfg_req); end
    n_cmp++; if (cfg_test_mode !== 1'b0) begin n_err++; $display("FAIL reset cfg_test_mode: got %b want 0", cfg_test_mode); end
    n_cmp++; if (lane_start !== 4'h0) begin n_err++; $display("FAIL reset lane_start: got %h want 0", lane_start); end
    n_cmp++; if (lane_sel !== 2'd0) begin n_err++; $display("FAIL reset lane_sel: got %0d want 0", lane_sel); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b want 0", done); end
    n_cmp++; if (error !== 1'b0) begin n_err++; $display("FAIL reset error: got %b want 0", error); end
    n_cmp++; if (lane_ok !== 4'h0) begin n_err++; $display("FAIL reset lane_ok: got %h want 0", lane_ok); end
    $display("info: idle seq_state=%0d", seq_state);
    reset = 1'b0;
    repeat (5) @(negedge clk_ref);
    #1;
    n_cmp++; if ({busy, cfg_req} !== 2'b00) begin n_err++; $display("FAIL idle_no_start busy/cfg_req: got %b want 00", {busy, cfg_req}); end
  endtask

  task automatic test_nominal();
    bit ok;
    set_all(50); ack_dly = 3; fco_dly = 10;
    run_training(ok); model_compute();
    n_cmp++;
    if ({ok, done, error, lane_ok, cfg_test_mode, busy, cfg_req} !== {1'b1, exp_done, exp_error, exp_ok, 3'b000}) begin
      n_err++; $display("FAIL nominal status: got %b want %b", {ok, done, error, lane_ok, cfg_test_mode, busy, cfg_req}, {1'b1, exp_done, exp_error, exp_ok, 3'b000});
    end
    n_cmp++; if (pulse_log != exp_pulses) begin n_err++; $display("FAIL nominal pulses: got '%s' want '%s'", pulse_log, exp_pulses); end
    n_cmp++; if (wr_log != "10") begin n_err++; $display("FAIL nominal cfg_writes: got '%s' want '10'", wr_log); end
    n_cmp++; if ({done, lane_ok} !== 5'h1F) begin n_err++; $display("FAIL nominal done/lane_ok: got %h want 1f", {done, lane_ok}); end
  endtask

  task automatic test_lane_retry();
    bit ok;
    set_all(50); lane_dly[2][0] = 0; lane_dly[2][1] = 0; lane_dly[2][2] = 0;
    ack_dly = 3; fco_dly = 10;
    run_training(ok); model_compute();
    n_cmp++;
    if ({ok, done, error, lane_ok, cfg_test_mode, busy, cfg_req} !== {1'b1, exp_done, exp_error, exp_ok, 3'b000}) begin
      n_err++; $display("FAIL lane_retry status: got %b want %b", {ok, done, error, lane_ok, cfg_test_mode, busy, cfg_req}, {1'b1, exp_done, exp_error, exp_ok, 3'b000});
    end
    n_cmp++; if (pulse_log != exp_pulses) begin n_err++; $display("FAIL lane_retry pulses: got '%s' want '%s'", pulse_log, exp_pulses); end
    n_cmp++; if (wr_log != "10") begin n_err++; $display("FAIL lane_retry cfg_writes: got '%s' want '10'", wr_log); end
    n_cmp++; if ({error, lane_ok} !== 5'h1B) begin n_err++; $display("FAIL lane_retry error/lane_ok: got %h want 1b", {error, lane_ok}); end
  endtask

  task automatic test_fco_timeout();
    bit ok;
    set_all(50); ack_dly = 2; fco_dly = 0;
    run_training(ok); model_compute();
    n_cmp++;
    if ({ok, done, error, lane_ok, cfg_test_mode, busy, cfg_req} !== {1'b1, exp_done, exp_error, exp_ok, 3'b000}) begin
      n_err++; $display("FAIL fco_timeout status: got %b want %b", {ok, done, error, lane_ok, cfg_test_mode, busy, cfg_req}, {1'b1, exp_done, exp_error, exp_ok, 3'b000});
    end
    n_cmp++; if (pulse_log != "") begin n_err++; $display("FAIL fco_timeout pulses: got '%s' want none", pulse_log); end
    n_cmp++; if (wr_log != "10") begin n_err++; $display("FAIL fco_timeout cfg_writes: got '%s' want '10'", wr_log); end
  endtask

  task automatic test_expiry_boundary();
    bit ok;
    set_all(50); lane_dly[1][0] = TO; lane_dly[3][0] = TO + 1; lane_dly[3][1] = 20;
    ack_dly = 3; fco_dly = 10;
    run_training(ok); model_compute();
    n_cmp++;
    if ({ok, done, error, lane_ok, cfg_test_mode, busy, cfg_req} !== {1'b1, exp_done, exp_error, exp_ok, 3'b000}) begin
      n_err++; $display("FAIL expiry_boundary status: got %b want %b", {ok, done, error, lane_ok, cfg_test_mode, busy, cfg_req}, {1'b1, exp_done, exp_error, exp_ok, 3'b000});
    end
    n_cmp++; if (pulse_log != exp_pulses) begin n_err++; $display("FAIL expiry_boundary pulses: got '%s' want '%s'", pulse_log, exp_pulses); end
  endtask

  task automatic test_reset_mid();
    bit found, ok;
    set_all(80); ack_dly = 3; fco_dly = 10;
    kick();
    found = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk_ref); #1;
      if (lane_start[1]) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL reset_mid reach_lane1: got none want lane_start[1]"); end
    repeat (5) @(negedge clk_ref);
    #1;
    n_cmp++; if ({busy, lane_ok} !== 5'b10001) begin n_err++; $display("FAIL reset_mid pre_state busy/lane_ok: got %b want 10001", {busy, lane_ok}); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({cfg_req, cfg_test_mode, lane_start, lane_sel, busy, done, error, lane_ok} !== 15'h0) begin
      n_err++; $display("FAIL reset_mid outputs: got %b want all zero", {cfg_req, cfg_test_mode, lane_start, lane_sel, busy, done, error, lane_ok});
    end
    @(negedge clk_ref); #1 reset = 1'b0;
    set_all(50);
    run_training(ok); model_compute();
    n_cmp++;
    if ({ok, done, error, lane_ok} !== {1'b1, exp_done, exp_error, exp_ok}) begin
      n_err++; $display("FAIL reset_mid retrain status: got %b want %b", {ok, done, error, lane_ok}, {1'b1, exp_done, exp_error, exp_ok});
    end
    n_cmp++; if (pulse_log != exp_pulses) begin n_err++; $display("FAIL reset_mid retrain pulses: got '%s' want '%s'", pulse_log, exp_pulses); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    set_all(50); ack_dly = 3; fco_dly = 10;
    noise_en = 1'b1;
    run_training(ok);
    noise_en = 1'b0;
    model_compute();
    n_cmp++;
    if ({ok, done, error, lane_ok, cfg_test_mode, busy, cfg_req} !== {1'b1, exp_done, exp_error, exp_ok, 3'b000}) begin
      n_err++; $display("FAIL back_to_back status: got %b want %b", {ok, done, error, lane_ok, cfg_test_mode, busy, cfg_req}, {1'b1, exp_done, exp_error, exp_ok, 3'b000});
    end
    n_cmp++; if (pulse_log != exp_pulses) begin n_err++; $display("FAIL back_to_back pulses: got '%s' want '%s'", pulse_log, exp_pulses); end
    n_cmp++; if (wr_log != "10") begin n_err++; $display("FAIL back_to_back cfg_writes: got '%s' want '10'", wr_log); end
  endtask

  task automatic test_random();
    bit ok;
    int r;
    for (int it = 0; it < 8; it++) begin
      ack_dly = $urandom_range(1, 5);
      fco_dly = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 60);
      for (int i = 0; i < NL; i++) begin
        for (int a = 0; a < MR; a++) begin
          r = $urandom_range(0, 9);
          if (r < 6)       lane_dly[i][a] = $urandom_range(1, TO);
          else if (r < 8)  lane_dly[i][a] = 0;
          else if (r == 8) lane_dly[i][a] = TO + $urandom_range(1, 30);
          else             lane_dly[i][a] = TO;
        end
      end
      run_training(ok); model_compute();
      n_cmp++;
      if ({ok, done, error, lane_ok, cfg_test_mode, busy, cfg_req} !== {1'b1, exp_done, exp_error, exp_ok, 3'b000}) begin
        n_err++; $display("FAIL random%0d status: got %b want %b", it, {ok, done, error, lane_ok, cfg_test_mode, busy, cfg_req}, {1'b1, exp_done, exp_error, exp_ok, 3'b000});
      end
      n_cmp++; if (pulse_log != exp_pulses) begin n_err++; $display("FAIL random%0d pulses: got '%s' want '%s'", it, pulse_log, exp_pulses); end
      n_cmp++; if (wr_log != "10") begin n_err++; $display("FAIL random%0d cfg_writes: got '%s' want '10'", it, wr_log); end
    end
  endtask

  task automatic test_onehot();
    n_cmp++; if (onehot_bad != 0) begin n_err++; $display("FAIL onehot lane_start multi-bit cycles: got %0d want 0", onehot_bad); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lane_retry();
    test_fco_timeout();
    test_expiry_boundary();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_onehot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
